lfsr_crypt_engine: RTL and testbench

LFSR_CRYPT_ENGINE -- requirements
Module: lfsr_crypt_engine

---
 rtl/lfsr_crypt_engine.sv | 102 ++++++++++
 tb/tb_lfsr_crypt_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_crypt_engine.sv
// lfsr_crypt_engine: LFSR stream cipher over PAD-framed messages.
// Optional LFSR_STRIP_LEAD_EN: decrypt drops leading PAD words of the window.
module lfsr_crypt_engine #(
    parameter int W = 8,
    parameter int FRAME_LEN = 64,
    parameter int MSG_LEN = 41,
    parameter logic [W-1:0] PAD = W'('h20)
) (
    input  logic                             CLK,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             cfg_mode,
    input  logic [W-1:0]                     cfg_taps,
    input  logic [W-1:0]                     cfg_seed,
    input  logic [$clog2(FRAME_LEN+1)-1:0]   cfg_pre_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [W-1:0]                     in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [W-1:0]                     out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);
    localparam int PW = $clog2(FRAME_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic mode, go, bad, active, win, can_load, adv, emit, keep;
    logic [W-1:0] taps, lfsr, word;
    logic [PW-1:0] pre_len, idx;
    logic [PW:0] win_end;
    assign go = state == IDLE && start;
    assign bad = {1'b0, cfg_pre_len} > (PW+1)'(FRAME_LEN - MSG_LEN);
    assign active = state == RUN && idx < PW'(FRAME_LEN);
    assign win_end = {1'b0, pre_len} + (PW+1)'(MSG_LEN);
    assign win = idx >= pre_len && {1'b0, idx} < win_end;
    assign can_load = !out_valid || out_ready;
    // encrypt pad words advance on buffer space alone; everything else needs an input handshake
    assign adv = active && (!mode && !win ? can_load : in_valid && in_ready);
    assign word = (mode || win ? in_data : PAD) ^ lfsr;
    assign emit = adv && (!mode || win) && keep;
`ifdef LFSR_STRIP_LEAD_EN
    logic seen;
    assign keep = !mode || seen || word != PAD;
    always_ff @(posedge CLK) begin
        if (!reset_n)
            seen <= 1'b0;
        else
            seen <= go ? 1'b0 : seen || (emit && mode);
    end
`else
    assign keep = 1'b1;
`endif
    always_ff @(posedge CLK) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE ? (go ? (bad ? DONE : RUN) : IDLE) :
                    state == RUN  ? (idx == PW'(FRAME_LEN) && can_load ? DONE : RUN) : IDLE;
    end
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
        in_ready = active && (mode || win) && can_load;
    end
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            mode      <= 1'b0;
            taps      <= '0;
            pre_len   <= '0;
            idx       <= '0;
            lfsr      <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (go) begin
                mode    <= cfg_mode;
                taps    <= cfg_taps;
                pre_len <= cfg_pre_len;
                lfsr    <= cfg_seed;
                idx     <= '0;
                err     <= bad;
            end else if (adv) begin
                lfsr <= {lfsr[W-2:0], ^(lfsr & taps)};
                idx  <= idx + 1'b1;
            end
            if (emit)
                out_data <= word;
            // decrypt's final emission is always the last window word, if anything is emitted at all
            out_last  <= emit ? (mode ? {1'b0, idx} == win_end - 1'b1 : idx == PW'(FRAME_LEN - 1))
                              : out_last && out_valid && !out_ready;
            out_valid <= emit || (out_valid && !out_ready);
        end
    end
endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// tb_lfsr_crypt_engine: directed frames for encrypt/decrypt, stalls, errors, reset abort.
// Define LFSR_STRIP_LEAD_EN to also exercise leading-PAD stripping.
module tb_lfsr_crypt_engine;
    localparam int FL = 64;
    localparam int ML = 41;
    logic CLK = 0, reset_n = 0, start = 0, cfg_mode = 0;
    logic [7:0] cfg_taps = 0, cfg_seed = 0, in_data = 0, out_data;
    logic [6:0] cfg_pre_len = 0;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_last, busy, done, err;
    logic [7:0] msg[ML], plain[ML], src[FL], got[FL], expv[FL], cipher[FL];
    int checks = 0, errors = 0, got_n, last_at, in_n;

    lfsr_crypt_engine dut (
        .CLK(CLK), .reset_n(reset_n), .start(start), .cfg_mode(cfg_mode),
        .cfg_taps(cfg_taps), .cfg_seed(cfg_seed), .cfg_pre_len(cfg_pre_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model(input logic [7:0] taps, input logic [7:0] seed, input int pre);
        logic [7:0] l, w;
        l = seed;
        for (int i = 0; i < FL; i++) begin
            w = 8'h20;
            if (i >= pre && i < pre + ML) w = plain[i - pre];
            expv[i] = w ^ l;
            l = {l[6:0], ^(l & taps)};
        end
    endtask

    task automatic run_frame(input logic mode, input logic [7:0] taps, input logic [7:0] seed,
                             input int pre, input int nin, input bit tog, input int abort_at);
        int ii;
        bit fin;
        ii = 0;
        fin = 0;
        got_n = 0;
        last_at = -1;
        @(negedge CLK);
        start = 1;
        cfg_mode = mode;
        cfg_taps = taps;
        cfg_seed = seed;
        cfg_pre_len = 7'(pre);
        out_ready = 1;
        @(negedge CLK);
        start = 0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            in_valid = ii < nin;
            in_data = ii < nin ? src[ii] : 8'h00;
            out_ready = tog ? c[0] : 1'b1;
            #1;
            if (done) fin = 1;
            if (in_valid && in_ready) ii++;
            if (out_valid && out_ready) begin
                if (got_n < FL) got[got_n] = out_data;
                if (out_last) last_at = got_n;
                got_n++;
            end
            if (abort_at >= 0 && got_n >= abort_at) fin = 1;
            if (!fin) @(negedge CLK);
        end
        in_n = ii;
        if (!fin) check("timeout", done, 1);
        if (abort_at < 0) in_valid = 0;
    endtask

    task automatic cmp_exp(input string tag, input int n);
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), got[i], expv[i]);
    endtask

    initial begin
        for (int i = 0; i < ML; i++) msg[i] = 8'h41 + 8'(i % 26);
        msg[0] = 8'h4D;
        msg[1] = 8'h72;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset_n = 1;

        // basic encrypt, pre_len 0
        plain = msg;
        for (int i = 0; i < ML; i++) src[i] = msg[i];
        model(8'hB4, 8'h01, 0);
        run_frame(0, 8'hB4, 8'h01, 0, ML, 0, -1);
        check("enc_count", got_n, 64);
        check("enc_w0", got[0], 8'h4C);
        check("enc_w1", got[1], 8'h70);
        check("enc_last", last_at, 63);
        check("enc_consumed", in_n, 41);
        check("enc_err", err, 0);
        cmp_exp("enc", FL);

        // out_ready toggling gives the same stream
        run_frame(0, 8'hB4, 8'h01, 0, ML, 1, -1);
        check("tog_count", got_n, 64);
        check("tog_last", last_at, 63);
        cmp_exp("tog", FL);

        // encrypt then decrypt with pre_len 9
        model(8'hB4, 8'h01, 9);
        run_frame(0, 8'hB4, 8'h01, 9, ML, 0, -1);
        check("enc9_count", got_n, 64);
        cmp_exp("enc9", FL);
        cipher = got;
        for (int i = 0; i < FL; i++) src[i] = cipher[i];
        run_frame(1, 8'hB4, 8'h01, 9, FL, 0, -1);
        check("dec_count", got_n, 41);
        check("dec_consumed", in_n, 64);
        check("dec_last", last_at, 40);
        for (int i = 0; i < ML; i++) check($sformatf("dec[%0d]", i), got[i], msg[i]);

        // seed 0: data passes unchanged
        for (int i = 0; i < ML; i++) src[i] = msg[i];
        run_frame(0, 8'hB4, 8'h00, 0, ML, 0, -1);
        check("seed0_w0", got[0], 8'h4D);
        check("seed0_w40", got[40], msg[40]);
        check("seed0_w41", got[41], 8'h20);

        // illegal pre_len
        run_frame(0, 8'hB4, 8'h01, 24, ML, 0, -1);
        check("err_flag", err, 1);
        check("err_outputs", got_n, 0);
        check("err_consumed", in_n, 0);
        @(negedge CLK);
        check("err_hold", err, 1);
        check("err_idle", busy, 0);

        // reset mid-frame then restart
        run_frame(0, 8'hB4, 8'h01, 0, ML, 0, 20);
        reset_n = 0;
        @(negedge CLK);
        in_valid = 0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out_data", out_data, 0);
        check("abort_err_clear", err, 0);
        reset_n = 1;
        model(8'hB4, 8'h01, 0);
        run_frame(0, 8'hB4, 8'h01, 0, ML, 0, -1);
        check("restart_count", got_n, 64);
        check("restart_w0", got[0], 8'h4C);
        cmp_exp("restart", FL);

`ifdef LFSR_STRIP_LEAD_EN
        for (int i = 0; i < ML; i++) plain[i] = 8'h20;
        plain[27] = 8'h41;
        plain[28] = 8'h6A;
        plain[29] = 8'h6F;
        plain[30] = 8'h6B;
        model(8'hB4, 8'h5A, 0);
        for (int i = 0; i < FL; i++) src[i] = expv[i];
        run_frame(1, 8'hB4, 8'h5A, 0, FL, 0, -1);
        check("strip_count", got_n, 14);
        check("strip_w0", got[0], 8'h41);
        check("strip_w3", got[3], 8'h6B);
        check("strip_w13", got[13], 8'h20);
        check("strip_last", last_at, 13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
